// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion paths (BCD-to-binary converter
// and the binary-to-BCD display path): FSM encoding, digit constants and
// the result-width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] ADJ     = 4'd3;
    localparam logic [3:0] ADJ_TH  = 4'd8;

    // Binary width needed to hold any value of 'digits' decimal digits.
    function automatic int bin_width(input int digits);
        return $clog2(10 ** digits);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD field correction step of reverse double-dabble:
// after a right shift, a field holding 8 or more is reduced by 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // 4-bit adjust, no borrow into neighbouring fields
    assign q = (d >= ADJ_TH) ? (d - ADJ) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One conversion per accepted start; done pulses 4*DIGITS+1 cycles after
// the accepting edge.
// Optional build macro: BCD_TO_BIN_ERR_EN -- flags captured digits > 9 on err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; captures bcd_in on accept
// S_SHIFT | one shift + field adjust per cycle, 4*DIGITS cycles
// S_DONE  | result transferred to bin_out, done pulse follows
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int BIN_W  = bin_width(DIGITS)
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int NIB_W = 4 * DIGITS;
    // The binary field is NIB_W wide (not BIN_W) so that every one of the
    // NIB_W shifted-out bits lands inside the register; the top bits of that
    // field are always zero for valid input and are simply not forwarded.
    localparam int SR_W  = 2 * NIB_W;
    localparam int CNT_W = $clog2(NIB_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB_W - 1);

    state_t            state, state_nxt;
    logic [SR_W-1:0]   sreg;
    logic [SR_W-1:0]   sreg_sh;
    logic [SR_W-1:0]   sreg_adj;
    logic [CNT_W-1:0]  cnt;
    logic              ld;
    logic              step;
    logic              fin;

    assign sreg_sh = sreg >> 1;
    assign sreg_adj[NIB_W-1:0] = sreg_sh[NIB_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (sreg_sh[NIB_W + 4*g +: 4]),
            .q (sreg_adj[NIB_W + 4*g +: 4])
        );
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the done cycle still belongs to the finished
    // conversion, so a held start re-triggers one cycle later
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !done)  state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath controls decoded from state
    always_comb begin
        ld   = 1'b0;
        step = 1'b0;
        fin  = 1'b0;
        case (state)
            S_IDLE:  ld   = start && !done;
            S_SHIFT: step = 1'b1;
            S_DONE:  fin  = 1'b1;
            default: ;
        endcase
    end

    // Shift register, shift counter and handshake/result registers
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sreg    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
        end else begin
            done <= fin;
            if (ld) begin
                sreg <= {bcd_in, {NIB_W{1'b0}}};
                cnt  <= '0;
                busy <= 1'b1;
            end
            if (step) begin
                sreg <= sreg_adj;
                cnt  <= cnt + 1'b1;
            end
            if (fin)  bin_out <= sreg[BIN_W-1:0];
            if (done) busy    <= 1'b0;
        end
    end

`ifdef BCD_TO_BIN_ERR_EN
    logic bad_in;
    logic err_pend;

    // Any digit above 9 in the word being captured
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
    end

    // Pending flag taken at capture, published together with bin_out
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            err_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (ld)  err_pend <= bad_in;
            if (fin) err      <= err_pend;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 2;
    localparam int LAT    = 4 * DIGITS + 1;
`ifdef BCD_TO_BIN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic [6:0] bin_out;
    logic       err;

    int vec   = 0;
    int fails = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int bcd_value(input logic [7:0] v);
        return 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic bit has_bad(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    // Behavioural model: a conversion is a countdown of LAT cycles from the
    // accepting edge; the done cycle blocks a new accept.
    int         left = 0;
    bit         model_valid = 1'b0;
    bit         was_done;
    int         cap_val;
    bit         cap_bad;
    logic       e_busy, e_done, e_err, e_bin_known;
    logic [6:0] e_bin;

    always @(posedge clk_sys) begin
        if (rst) begin
            left = 0; e_busy = 0; e_done = 0; e_err = 0;
            e_bin = '0; e_bin_known = 1;
        end else begin
            was_done = e_done;
            e_done   = 0;
            if (left == 0) begin
                if (start && !was_done) begin
                    left    = LAT;
                    cap_val = bcd_value(bcd_in);
                    cap_bad = has_bad(bcd_in);
                    e_busy  = 1;
                end else begin
                    e_busy = 0;
                end
            end else begin
                left--;
                e_busy = 1;
                if (left == 0) begin
                    e_done      = 1;
                    e_bin       = 7'(cap_val);
                    e_bin_known = !cap_bad;
                    e_err       = ERR_EN ? cap_bad : 1'b0;
                end
            end
        end
        model_valid = 1'b1;
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk_sys) begin
        if (model_valid) begin
            vec++;
            if (busy !== e_busy) begin
                fails++;
                $display("FAIL busy t=%0t got %b exp %b", $time, busy, e_busy);
            end
            vec++;
            if (done !== e_done) begin
                fails++;
                $display("FAIL done t=%0t got %b exp %b", $time, done, e_done);
            end
            vec++;
            if (err !== e_err) begin
                fails++;
                $display("FAIL err t=%0t got %b exp %b", $time, err, e_err);
            end
            if (e_bin_known) begin
                vec++;
                if (bin_out !== e_bin) begin
                    fails++;
                    $display("FAIL bin_out t=%0t got %0d exp %0d", $time, bin_out, e_bin);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        vec++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    // Waits for done, bounded; k counts negedges waited
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (done !== 1'b1 && k < 40);
        if (done !== 1'b1) begin
            vec++;
            fails++;
            $display("FAIL done_timeout got no done after %0d cycles exp done", k);
        end
    endtask

    // Called at a negedge; pulses start for one cycle, checks latency and
    // (if exp_bin >= 0) the result, then steps past the done cycle.
    task automatic run_one(input logic [7:0] v, input int exp_bin, input string nm);
        int k;
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk_sys);
        start  = 1'b0;
        wait_done(k);
        chk({nm, "_latency"}, k, 9);
        if (exp_bin >= 0) chk(nm, int'(bin_out), exp_bin);
        @(negedge clk_sys);
    endtask

    initial begin
        int k;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin",  int'(bin_out), 0);
        chk("rst_err",  int'(err), 0);
        rst = 1'b0;
        @(negedge clk_sys);

        // single conversion of 99
        run_one(8'h99, 99, "conv_99");
        chk("conv_99_err", int'(err), 0);

        // start held high: back-to-back 19, 00, 10
        bcd_in = 8'h19;
        start  = 1'b1;
        @(negedge clk_sys);
        chk("b2b_busy", int'(busy), 1);
        wait_done(k);
        chk("b2b_19", int'(bin_out), 19);
        bcd_in = 8'h00;
        wait_done(k);
        chk("b2b_spacing", k, LAT + 2);
        chk("b2b_00", int'(bin_out), 0);
        bcd_in = 8'h10;
        wait_done(k);
        chk("b2b_10", int'(bin_out), 10);
        start = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);

        // all valid two-digit inputs; model checks every cycle
        for (int hi = 0; hi < 10; hi++)
            for (int lo = 0; lo < 10; lo++)
                run_one({4'(hi), 4'(lo)}, 10 * hi + lo, "exh");

        // start during SHIFT is ignored, input changes do not matter
        bcd_in = 8'h37;
        start  = 1'b1;
        @(negedge clk_sys);
        start  = 1'b0;
        repeat (2) @(negedge clk_sys);
        bcd_in = 8'h55;
        start  = 1'b1;
        @(negedge clk_sys);
        start  = 1'b0;
        bcd_in = 8'h81;
        wait_done(k);
        chk("ignore_start", int'(bin_out), 37);
        @(negedge clk_sys);

        // reset 4 cycles into a conversion, with start asserted alongside
        bcd_in = 8'h64;
        start  = 1'b1;
        @(negedge clk_sys);
        start  = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk_sys);
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_bin",  int'(bin_out), 0);
        chk("abort_done", int'(done), 0);
        repeat (12) @(negedge clk_sys);
        run_one(8'h58, 58, "after_abort");

        // invalid digit, then valid follow-up
        run_one(8'h4A, -1, "bad_digit");
        chk("bad_digit_err", int'(err), ERR_EN ? 1 : 0);
        run_one(8'h42, 42, "after_bad");
        chk("after_bad_err", int'(err), 0);

        repeat (3) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
